// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : morse_pkg
//  Brief   : Shared state encoding and width helper for the Morse beacon keyer.
//  Revision: 1.0
// ============================================================================
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } morse_state_e;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/morse_dot_timebase.sv
`default_nettype none
// ============================================================================
//  Module  : morse_dot_timebase
//  Brief   : Dot-rate down-counter; emits a 1-cycle tick every period_i cycles.
//  Revision: 1.0
// ============================================================================
module morse_dot_timebase #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick_o = (cnt_q == '0);

    // Reload on the clear edge so the first dot after a clear is a full period.
    always_comb begin
        cnt_d = cnt_q - DIV_W'(1);
        if (clr_i || tick_o) begin
            cnt_d = period_i - DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/morse_beacon_gen.sv
`default_nettype none
// ============================================================================
//  Module  : morse_beacon_gen
//  Brief   : RAM-backed Morse keyer with run-time dot/message length and looping.
//  Revision: 1.0
// ============================================================================
module morse_beacon_gen
    import morse_pkg::*;
#(
    parameter int WORD_W   = 8,
    parameter int DEPTH    = 16,
    parameter int DIV_W    = 24,
    parameter int GAP_DOTS = 14,
    parameter int LEN_W    = $clog2(DEPTH*WORD_W+1)
) (
    input  logic                       morse_clk,
    input  logic                       sys_rst,
    input  logic                       wr_en,
    input  logic [width_of(DEPTH)-1:0] wr_addr,
    input  logic [WORD_W-1:0]          wr_data,
    input  logic [LEN_W-1:0]           msg_len,
    input  logic [DIV_W-1:0]           dot_len,
    input  logic                       loop_en,
    input  logic                       start,
    input  logic                       stop,
    output logic                       key,
    output logic                       busy,
    output logic                       done,
    output logic [LEN_W-1:0]           bit_ptr
);

    localparam int AW = width_of(DEPTH);
    localparam int BW = width_of(WORD_W);
    localparam int GW = width_of(GAP_DOTS);
    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(DEPTH*WORD_W);

    logic [WORD_W-1:0] mem_q [DEPTH];

    morse_state_e      state_q, state_d;
    logic [LEN_W-1:0]  ptr_q, ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DIV_W-1:0]  dot_q, dot_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              done_q, done_d;
    logic              key_q;

    logic              w_tick;
    logic              w_tb_clr;
    logic              w_wrap;
    logic [LEN_W-1:0]  w_len_in;
    logic [DIV_W-1:0]  w_dot_in;
    logic [AW-1:0]     w_rd_word;
    logic [BW-1:0]     w_rd_bit;

    assign w_len_in = (msg_len > c_MAX_LEN) ? c_MAX_LEN : msg_len;
    assign w_dot_in = (dot_len == '0) ? DIV_W'(1) : dot_len;

    morse_dot_timebase #(
        .DIV_W    (DIV_W)
    ) u_timebase (
        .clk      (morse_clk),
        .rst      (sys_rst),
        .clr_i    (w_tb_clr),
        .period_i (dot_d),
        .tick_o   (w_tick)
    );

    // w_wrap marks any (re)start of a pass: from IDLE, or at the end of a loop pass/gap.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        dot_d    = dot_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        w_tb_clr = 1'b0;
        w_wrap   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_wrap = 1'b1;
                end
            end
            ST_PLAY: begin
                if (w_tick) begin
                    if (ptr_q == len_q - LEN_W'(1)) begin
                        if (!loop_en) begin
                            state_d = ST_IDLE;
                            ptr_d   = '0;
                            done_d  = 1'b1;
                        end else if (GAP_DOTS == 0) begin
                            w_wrap = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            ptr_d   = '0;
                            gap_d   = '0;
                        end
                    end else begin
                        ptr_d = ptr_q + LEN_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    if (gap_q == GW'(GAP_DOTS - 1)) begin
                        w_wrap = 1'b1;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase

        if (w_wrap) begin
            ptr_d = '0;
            if (w_len_in == '0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d  = ST_PLAY;
                len_d    = w_len_in;
                dot_d    = w_dot_in;
                w_tb_clr = 1'b1;
            end
        end

        if (stop) begin
            state_d  = ST_IDLE;
            ptr_d    = '0;
            len_d    = len_q;
            dot_d    = dot_q;
            done_d   = 1'b0;
            w_tb_clr = 1'b0;
        end
    end

    assign w_rd_word = AW'(ptr_d / WORD_W);
    assign w_rd_bit  = BW'(ptr_d % WORD_W);

    always_ff @(posedge morse_clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Key is the registered RAM read of the bit being entered; same-cycle writes show next read.
    always_ff @(posedge morse_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            dot_q   <= DIV_W'(1);
            gap_q   <= '0;
            done_q  <= 1'b0;
            key_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            dot_q   <= dot_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            key_q   <= (state_d == ST_PLAY) ? mem_q[w_rd_word][w_rd_bit] : 1'b0;
        end
    end

    assign key     = key_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign bit_ptr = ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_beacon_gen.sv
`default_nettype none
// ============================================================================
//  Module  : tb_morse_beacon_gen
//  Brief   : Directed and randomized bench for morse_beacon_gen with a bit-level model.
//  Revision: 1.0
// ============================================================================
module tb_morse_beacon_gen;

    localparam int WORD_W   = 8;
    localparam int DEPTH    = 16;
    localparam int DIV_W    = 24;
    localparam int GAP_DOTS = 2;
    localparam int LEN_W    = $clog2(DEPTH*WORD_W+1);
    localparam int MAXLEN   = DEPTH*WORD_W;

    logic              morse_clk = 1'b0;
    logic              sys_rst;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [7:0]        wr_data;
    logic [LEN_W-1:0]  msg_len;
    logic [DIV_W-1:0]  dot_len;
    logic              loop_en;
    logic              start;
    logic              stop;
    logic              key;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  bit_ptr;

    logic [7:0] ram_model [DEPTH];
    int n_assert = 0;
    int n_fail   = 0;

    morse_beacon_gen #(
        .WORD_W   (WORD_W),
        .DEPTH    (DEPTH),
        .DIV_W    (DIV_W),
        .GAP_DOTS (GAP_DOTS)
    ) dut (
        .morse_clk (morse_clk),
        .sys_rst   (sys_rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .msg_len   (msg_len),
        .dot_len   (dot_len),
        .loop_en   (loop_en),
        .start     (start),
        .stop      (stop),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .bit_ptr   (bit_ptr)
    );

    always #5 morse_clk = ~morse_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge morse_clk);
        #1;
    endtask

    function automatic logic model_bit(input int i);
        logic [7:0] w;
        w = ram_model[i / WORD_W];
        return w[i % WORD_W];
    endfunction

    task automatic wr(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        ram_model[a] = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic kick(input int len, input int dot, input logic lp);
        msg_len = LEN_W'(len);
        dot_len = DIV_W'(dot);
        loop_en = lp;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    // ev_kind: 1 clear loop_en, 2 start pulse + dot_len change, 3 write word 15
    task automatic check_pass(input int len, input int dot, input int ev_bit, input int ev_kind);
        for (int i = 0; i < len; i++) begin
            for (int c = 0; c < dot; c++) begin
                chk("key", key, model_bit(i));
                chk("busy", busy, 1);
                chk("bit_ptr", bit_ptr, i);
                chk("done", done, 0);
                start = 1'b0;
                wr_en = 1'b0;
                if (i == ev_bit && c == 0) begin
                    case (ev_kind)
                        1: loop_en = 1'b0;
                        2: begin
                            start   = 1'b1;
                            dot_len = DIV_W'(7);
                        end
                        3: begin
                            wr_en   = 1'b1;
                            wr_addr = 4'hF;
                            wr_data = 8'($urandom);
                            ram_model[15] = wr_data;
                        end
                        default: ;
                    endcase
                end
                step();
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic check_gap(input int dot);
        for (int c = 0; c < GAP_DOTS*dot; c++) begin
            chk("gap_key", key, 0);
            chk("gap_busy", busy, 1);
            chk("gap_done", done, 0);
            step();
        end
    endtask

    task automatic check_done();
        chk("end_key", key, 0);
        chk("end_busy", busy, 0);
        chk("end_done", done, 1);
        step();
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        int d;
        int len;
        int eff_len;
        sys_rst = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        msg_len = '0;
        dot_len = DIV_W'(1);
        loop_en = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        for (int i = 0; i < DEPTH; i++) ram_model[i] = '0;
        step();
        step();
        sys_rst = 1'b0;
        chk("rst_key", key, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ptr", bit_ptr, 0);

        // one-shot, with an ignored start and dot_len change mid-play
        wr(0, 8'b0111_0101);
        kick(8, 3, 1'b0);
        check_pass(8, 3, 2, 2);
        check_done();

        // loop with gap, loop_en cleared during second pass
        kick(8, 3, 1'b1);
        check_pass(8, 3, -1, 0);
        check_gap(3);
        check_pass(8, 3, 3, 1);
        check_done();

        // stop at bit 4, then start+stop together
        kick(8, 3, 1'b0);
        check_pass(4, 3, -1, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_key", key, 0);
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("stop_nodone", done, 0);
        end
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_done", done, 0);
        step();
        chk("ss_busy2", busy, 0);
        chk("ss_done2", done, 0);

        // zero-length message and zero dot length
        kick(0, 3, 1'b0);
        chk("len0_done", done, 1);
        chk("len0_key", key, 0);
        chk("len0_busy", busy, 0);
        step();
        chk("len0_done2", done, 0);
        kick(8, 0, 1'b0);
        check_pass(8, 1, -1, 0);
        check_done();

        // looping with msg_len dropping to 0 before the wrap
        kick(8, 1, 1'b1);
        msg_len = '0;
        check_pass(8, 1, -1, 0);
        check_gap(1);
        check_done();

        // cross-word message, looping, random dot length
        wr(0, 8'hFF);
        wr(1, 8'h00);
        d = $urandom_range(1, 3);
        kick(12, d, 1'b1);
        check_pass(12, d, -1, 0);
        check_gap(d);
        check_pass(12, d, 5, 1);
        check_done();

        // reset mid-playback, then identical replay
        kick(12, 2, 1'b0);
        check_pass(5, 2, -1, 0);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        chk("mrst_key", key, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ptr", bit_ptr, 0);
        chk("mrst_done", done, 0);
        kick(12, 2, 1'b0);
        check_pass(12, 2, -1, 0);
        check_done();

        // random contents and lengths, including over-length clamp and live writes
        for (int it = 0; it < 4; it++) begin
            for (int w = 0; w < DEPTH; w++) wr(w, 8'($urandom));
            len = (it == 0) ? MAXLEN + 7 : $urandom_range(1, MAXLEN + 12);
            d   = $urandom_range(0, 2);
            eff_len = (len > MAXLEN) ? MAXLEN : len;
            kick(len, d, 1'b0);
            check_pass(eff_len, (d == 0) ? 1 : d, 0, 3);
            check_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
